multi_rate_divider: RTL and testbench

//  Parametrised successor of the 3-switch frequency divider: derives one of NRATES tick rates from clk.

---
 rtl/freq_div_pkg.sv | 18 +
 rtl/switch_sync.sv | 26 ++
 rtl/multi_rate_divider.sv | 156 +++++++++++++++
 tb/tb_multi_rate_divider.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// rtl/freq_div_pkg.sv - shared types, defaults and divisor helper for the multi-rate divider
package freq_div_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } div_state_t;

   localparam int DEF_CLK_HZ = 50_000_000;
   localparam int DEF_NRATES = 3;
   localparam int DEF_RATE_HZ [DEF_NRATES] = '{1, 20, 60};

   function automatic int div_of(int clk_hz, int rate_hz);
      return (rate_hz > 0) ? clk_hz / rate_hz : 0;
   endfunction

endpackage

// File: rtl/switch_sync.sv
// rtl/switch_sync.sv - two-flop synchroniser for slow asynchronous switch inputs
module switch_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/multi_rate_divider.sv
// rtl/multi_rate_divider.sv - selectable-rate tick / square-wave generator
// Rate and mode changes are deferred to a period boundary so neither output ever shows a runt.
module multi_rate_divider
   import freq_div_pkg::*;
#(
   parameter int CLK_HZ           = DEF_CLK_HZ,
   parameter int NRATES           = DEF_NRATES,
   parameter int RATE_HZ [NRATES] = DEF_RATE_HZ,
   parameter int NBITS            = $clog2(CLK_HZ)
) (
   input  logic              clk,
   input  logic              _rst,
   input  logic [NRATES-1:0] sel,
   input  logic              mode_square,
   output logic              tick,
   output logic              wave,
   output logic [NRATES-1:0] led,
   output logic              active,
   output logic              sel_err
);

   localparam int IW = (NRATES > 1) ? $clog2(NRATES) : 1;

   logic [NBITS-1:0] w_dm1  [NRATES];
   logic [NBITS-1:0] w_half [NRATES];

   for (genvar g = 0; g < NRATES; g++) begin : g_rate
      localparam int D = div_of(CLK_HZ, RATE_HZ[g]);
      if (RATE_HZ[g] <= 0 || D < 2 || longint'(D - 1) >= (longint'(1) << NBITS)) begin : g_bad
         $error("multi_rate_divider: rate %0d yields unusable divisor %0d", g, D);
      end
      assign w_dm1[g]  = NBITS'(D - 1);
      assign w_half[g] = NBITS'(D / 2);
   end

   logic [NRATES:0]   w_sync;
   logic [NRATES-1:0] w_sel_s;
   logic              w_mode_s;

   switch_sync #(.WIDTH(NRATES + 1)) u_sync (
      .clk     (clk),
      .i_rst_n (_rst),
      .i_d     ({mode_square, sel}),
      .o_q     (w_sync)
   );

   assign w_sel_s  = w_sync[NRATES-1:0];
   assign w_mode_s = w_sync[NRATES];

   div_state_t        r_state;
   logic [IW-1:0]     r_cur;
   logic              r_mode;
   logic [IW-1:0]     r_pidx;
   logic              r_pmode;
   logic [NBITS-1:0]  r_cnt;
   logic              r_tick;
   logic              r_wave;
   logic [NRATES-1:0] r_led;
   logic              r_active;
   logic              r_sel_err;

   logic [IW-1:0]     w_idx;
   logic              w_multi;
   logic              w_legal;
   logic              w_differs;
   logic              w_wrap;
   logic [NBITS-1:0]  w_cnt_inc;
   logic [NBITS-1:0]  w_half_cur;

   always_comb begin
      w_idx = '0;
      for (int i = 0; i < NRATES; i++) begin
         if (w_sel_s[i]) w_idx = IW'(i);
      end
   end

   // x & (x-1) clears the lowest set bit: non-zero means more than one switch is on
   assign w_multi    = (w_sel_s & (w_sel_s - NRATES'(1))) != '0;
   assign w_legal    = (w_sel_s != '0) && !w_multi;
   assign w_differs  = (w_idx != r_cur) || (w_mode_s != r_mode);
   assign w_wrap     = (r_cnt == w_dm1[r_cur]);
   assign w_cnt_inc  = r_cnt + NBITS'(1);
   assign w_half_cur = w_half[r_cur];

   always_ff @(posedge clk or negedge _rst) begin
      if (!_rst) begin
         r_state   <= OFF;
         r_cur     <= '0;
         r_mode    <= 1'b0;
         r_pidx    <= '0;
         r_pmode   <= 1'b0;
         r_cnt     <= '0;
         r_tick    <= 1'b0;
         r_wave    <= 1'b0;
         r_led     <= '0;
         r_active  <= 1'b0;
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= w_multi;
         r_tick    <= 1'b0;
         case (r_state)
            OFF: begin
               if (w_legal) begin
                  r_state  <= RUN;
                  r_cur    <= w_idx;
                  r_mode   <= w_mode_s;
                  r_cnt    <= '0;
                  r_led    <= NRATES'(1) << w_idx;
                  r_active <= 1'b1;
                  r_wave   <= w_mode_s;
               end
            end
            RUN, PEND: begin
               if (w_sel_s == '0) begin
                  r_state  <= OFF;
                  r_cnt    <= '0;
                  r_led    <= '0;
                  r_active <= 1'b0;
                  r_wave   <= 1'b0;
               end else begin
                  if (w_legal && (r_state == PEND || w_differs)) begin
                     r_pidx  <= w_idx;
                     r_pmode <= w_mode_s;
                  end
                  if (w_wrap) begin
                     // cnt restarts at 0, which is the high phase in square mode and the tick in pulse mode
                     r_cnt  <= '0;
                     r_tick <= 1'b1;
                     r_wave <= 1'b1;
                     if (r_state == PEND) begin
                        r_state <= RUN;
                        r_cur   <= r_pidx;
                        r_mode  <= r_pmode;
                        r_led   <= NRATES'(1) << r_pidx;
                     end else if (w_legal && w_differs) begin
                        r_state <= PEND;
                     end
                  end else begin
                     r_cnt  <= w_cnt_inc;
                     r_wave <= r_mode && (w_cnt_inc < w_half_cur);
                     if (w_legal && w_differs) r_state <= PEND;
                  end
               end
            end
            default: r_state <= OFF;
         endcase
      end
   end

   assign tick    = r_tick;
   assign wave    = r_wave;
   assign led     = r_led;
   assign active  = r_active;
   assign sel_err = r_sel_err;

endmodule

// File: tb/tb_multi_rate_divider.sv
// tb/tb_multi_rate_divider.sv - self-checking bench for multi_rate_divider
module tb_multi_rate_divider;

   localparam int CLK_HZ = 120;
   localparam int NRATES = 3;
   localparam int RATE_HZ [NRATES] = '{1, 20, 60};

   logic       clk  = 1'b0;
   logic       rst  = 1'b0;
   logic [2:0] sel  = 3'b000;
   logic       mode = 1'b0;
   logic       tick, wave, active, sel_err;
   logic [2:0] led;

   int n_cmp = 0;
   int n_bad = 0;

   multi_rate_divider #(
      .CLK_HZ  (CLK_HZ),
      .NRATES  (NRATES),
      .RATE_HZ (RATE_HZ)
   ) dut (
      .clk         (clk),
      ._rst        (rst),
      .sel         (sel),
      .mode_square (mode),
      .tick        (tick),
      .wave        (wave),
      .led         (led),
      .active      (active),
      .sel_err     (sel_err)
   );

   always #5 clk = ~clk;

   logic [3:0] s1, s2;
   bit  m_on, m_mode, m_pend, m_pmode;
   int  m_idx, m_ph, m_pidx;
   bit  e_tick, e_wave, e_err;
   int  cyc_n = 0;

   function automatic int dof(int i);
      return CLK_HZ / RATE_HZ[i];
   endfunction

   task automatic model_reset();
      s1 = '0; s2 = '0;
      m_on = 0; m_mode = 0; m_pend = 0; m_pmode = 0;
      m_idx = 0; m_ph = 0; m_pidx = 0;
      e_tick = 0; e_wave = 0; e_err = 0;
   endtask

   task automatic model_edge();
      logic [2:0] s;
      bit ms, legal, differs;
      int ones, idx;
      if (!rst) begin
         model_reset();
         return;
      end
      s = s2[2:0];
      ms = s2[3];
      ones = $countones(s);
      idx = 0;
      for (int i = 0; i < 3; i++) if (s[i]) idx = i;
      legal = (ones == 1);
      e_err = (ones > 1);
      e_tick = 0;
      if (!m_on) begin
         if (legal) begin
            m_on = 1; m_idx = idx; m_mode = ms; m_ph = 0; m_pend = 0;
         end
      end else if (ones == 0) begin
         m_on = 0; m_pend = 0; m_ph = 0;
      end else begin
         differs = legal && (idx != m_idx || ms != m_mode);
         if (m_ph == dof(m_idx) - 1) begin
            m_ph = 0;
            e_tick = 1;
            if (m_pend) begin
               m_idx = m_pidx; m_mode = m_pmode; m_pend = 0;
            end else if (differs) begin
               m_pend = 1; m_pidx = idx; m_pmode = ms;
            end
         end else begin
            m_ph++;
            if (legal && (m_pend || differs)) begin
               m_pend = 1; m_pidx = idx; m_pmode = ms;
            end
         end
      end
      e_wave = m_on && (m_mode ? (m_ph < dof(m_idx) / 2) : e_tick);
      s2 = s1;
      s1 = {mode, sel};
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("tick", 32'(tick), 32'(e_tick));
      chk("wave", 32'(wave), 32'(e_wave));
      chk("led", 32'(led), m_on ? (32'd1 << m_idx) : 32'd0);
      chk("active", 32'(active), 32'(m_on));
      chk("sel_err", 32'(sel_err), 32'(e_err));
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         model_edge();
         cyc_n++;
         #1;
         check_all();
      end
   endtask

   logic [2:0] sel_tab [10];
   int  cnt, last, ntick;
   bit  found;

   initial begin
      sel_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b011, 3'b110, 3'b111};
      model_reset();

      // reset held with a legal request present
      sel = 3'b001;
      step(3);
      rst = 1'b1;
      cnt = 0;
      found = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         step(1);
         if (active) begin found = 1; cnt = i; end
      end
      chk("rst_to_active", 32'(cnt), 32'd3);
      cnt = 0;
      found = 0;
      for (int i = 1; i <= 200 && !found; i++) begin
         step(1);
         if (tick) begin found = 1; cnt = i; end
      end
      chk("first_tick", 32'(cnt), 32'd120);

      // pulse mode period on D=6
      sel = 3'b000;
      step(4);
      sel = 3'b010;
      step(4);
      last = -1;
      ntick = 0;
      for (int i = 0; i < 130; i++) begin
         step(1);
         if (tick) begin
            if (last >= 0) chk("period6", 32'(cyc_n - last), 32'd6);
            last = cyc_n;
            ntick++;
         end
      end
      chk("tick_count_ge20", 32'(ntick >= 20), 32'd1);

      // square mode on D=2 then D=6
      mode = 1'b1;
      sel = 3'b100;
      step(20);
      sel = 3'b010;
      step(30);

      // rate change mid-period on D=120
      sel = 3'b000;
      mode = 1'b0;
      step(4);
      sel = 3'b001;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(1);
         if (m_on && m_idx == 0 && m_ph == 48) found = 1;
      end
      chk("reach_cnt48", 32'(found), 32'd1);
      sel = 3'b100;
      step(70);
      chk("led_held", 32'(led), 32'b001);
      step(10);

      // multi-hot selection while running, then off
      sel = 3'b000;
      step(4);
      sel = 3'b010;
      step(20);
      sel = 3'b011;
      step(30);
      chk("sel_err_high", 32'(sel_err), 32'd1);
      sel = 3'b000;
      step(5);

      // asynchronous reset mid-period
      mode = 1'b1;
      sel = 3'b010;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1);
         if (m_on && m_idx == 1 && m_ph == 3) found = 1;
      end
      chk("reach_cnt3", 32'(found), 32'd1);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all();
      step(2);
      rst = 1'b1;
      step(10);

      // randomized switch activity
      for (int seg = 0; seg < 40; seg++) begin
         sel  = sel_tab[$urandom_range(0, 9)];
         mode = 1'($urandom_range(0, 1));
         step($urandom_range(1, 30));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
